// File: rtl/sram_bus_responder_if.sv
// 68k bus and SRAM control signals seen by the on-board SRAM responder.
// The master side drives the 68k strobes and decode; the slave side drives the SRAM pins and Dtack_L.
interface sram_bus_responder_if;
  logic        as_l;
  logic        uds_l;
  logic        lds_l;
  logic        rw_h;
  logic        sram_select_h;
  logic [16:0] address;
  logic [3:0]  sram_ce_l;
  logic        sram_oe_l;
  logic        sram_we_l;
  logic        sram_ub_l;
  logic        sram_lb_l;
  logic        dtack_l;
  logic        busy_h;

  modport master (
    output as_l, uds_l, lds_l, rw_h, sram_select_h, address,
    input  sram_ce_l, sram_oe_l, sram_we_l, sram_ub_l, sram_lb_l, dtack_l, busy_h
  );

  modport slave (
    input  as_l, uds_l, lds_l, rw_h, sram_select_h, address,
    output sram_ce_l, sram_oe_l, sram_we_l, sram_ub_l, sram_lb_l, dtack_l, busy_h
  );
endinterface

// File: rtl/sram_bus_responder.sv
// 68k bus responder for the 256 KB on-board SRAM: drives per-block chip enables, OE/WE and byte
// lanes for a programmable number of wait states, then holds Dtack_L until the CPU drops AS_L.
module sram_bus_responder #(
  parameter int unsigned WAIT_STATES = 2
) (
  input logic                  i_clock,
  input logic                  i_reset_l,
  sram_bus_responder_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StAck, StRecover} state_e;

  localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

  state_e     r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_ce_l;
  logic       r_oe_l;
  logic       r_we_l;
  logic       r_ub_l;
  logic       r_lb_l;
  logic       r_dtack_l;
  logic       r_busy_h;

  logic       w_start;
  logic [3:0] w_ce_sel_l;
  logic       w_unused_addr;

  assign w_start = !bus.as_l && bus.sram_select_h && (!bus.uds_l || !bus.lds_l);
  assign w_ce_sel_l = ~(4'b0001 << bus.address[16:15]);
  // Only the block select bits matter here; the SRAM sees A14-A0 directly.
  assign w_unused_addr = ^bus.address[14:0];

  // The registered control outputs double as the latched block/direction/strobe values.
  always_ff @(posedge i_clock or negedge i_reset_l) begin
    if (!i_reset_l) begin
      r_state   <= StIdle;
      r_cnt     <= 4'd0;
      r_ce_l    <= 4'b1111;
      r_oe_l    <= 1'b1;
      r_we_l    <= 1'b1;
      r_ub_l    <= 1'b1;
      r_lb_l    <= 1'b1;
      r_dtack_l <= 1'b1;
      r_busy_h  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state  <= StAccess;
            r_cnt    <= WaitLoad;
            r_ce_l   <= w_ce_sel_l;
            r_oe_l   <= ~bus.rw_h;
            r_we_l   <= bus.rw_h;
            r_ub_l   <= bus.uds_l;
            r_lb_l   <= bus.lds_l;
            r_busy_h <= 1'b1;
          end
        end
        StAccess: begin
          if (bus.as_l) begin
            r_state <= StRecover;
            r_ce_l  <= 4'b1111;
            r_oe_l  <= 1'b1;
            r_we_l  <= 1'b1;
            r_ub_l  <= 1'b1;
            r_lb_l  <= 1'b1;
          end else if (r_cnt == 4'd0) begin
            // Release WE while CE stays low so write data hold is met.
            r_state   <= StAck;
            r_we_l    <= 1'b1;
            r_dtack_l <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StAck: begin
          if (bus.as_l) begin
            r_state   <= StRecover;
            r_ce_l    <= 4'b1111;
            r_oe_l    <= 1'b1;
            r_we_l    <= 1'b1;
            r_ub_l    <= 1'b1;
            r_lb_l    <= 1'b1;
            r_dtack_l <= 1'b1;
          end
        end
        StRecover: begin
          r_state  <= StIdle;
          r_busy_h <= 1'b0;
        end
        default: begin
          r_state   <= StIdle;
          r_ce_l    <= 4'b1111;
          r_oe_l    <= 1'b1;
          r_we_l    <= 1'b1;
          r_ub_l    <= 1'b1;
          r_lb_l    <= 1'b1;
          r_dtack_l <= 1'b1;
          r_busy_h  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sram_ce_l = r_ce_l;
  assign bus.sram_oe_l = r_oe_l;
  assign bus.sram_we_l = r_we_l;
  assign bus.sram_ub_l = r_ub_l;
  assign bus.sram_lb_l = r_lb_l;
  assign bus.dtack_l   = r_dtack_l;
  assign bus.busy_h    = r_busy_h;

endmodule

// File: tb/tb_sram_bus_responder.sv
// Bench for sram_bus_responder: two instances (2 and 0 wait states) share one 68k bus stimulus and
// are compared every cycle against a transaction-timeline model of the access.
module tb_sram_bus_responder;

  localparam int unsigned W0 = 2;
  localparam int unsigned W1 = 0;
  // {ce_l[3:0], oe_l, we_l, ub_l, lb_l, dtack_l, busy_h}
  localparam logic [9:0] IdleV    = 10'b1111111110;
  localparam logic [9:0] RecoverV = 10'b1111111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        as_l = 1'b1;
  logic        uds_l = 1'b1;
  logic        lds_l = 1'b1;
  logic        rw_h = 1'b1;
  logic        sel_h = 1'b0;
  logic [16:0] addr = '0;
  int          tests = 0;
  int          fails = 0;

  sram_bus_responder_if bus0 ();
  sram_bus_responder_if bus1 ();

  assign bus0.as_l = as_l;
  assign bus0.uds_l = uds_l;
  assign bus0.lds_l = lds_l;
  assign bus0.rw_h = rw_h;
  assign bus0.sram_select_h = sel_h;
  assign bus0.address = addr;
  assign bus1.as_l = as_l;
  assign bus1.uds_l = uds_l;
  assign bus1.lds_l = lds_l;
  assign bus1.rw_h = rw_h;
  assign bus1.sram_select_h = sel_h;
  assign bus1.address = addr;

  sram_bus_responder #(.WAIT_STATES(W0)) u_dut0 (.i_clock(clk), .i_reset_l(rst_n), .bus(bus0));
  sram_bus_responder #(.WAIT_STATES(W1)) u_dut1 (.i_clock(clk), .i_reset_l(rst_n), .bus(bus1));

  wire [9:0] obs0 = {bus0.sram_ce_l, bus0.sram_oe_l, bus0.sram_we_l, bus0.sram_ub_l,
                     bus0.sram_lb_l, bus0.dtack_l, bus0.busy_h};
  wire [9:0] obs1 = {bus1.sram_ce_l, bus1.sram_oe_l, bus1.sram_we_l, bus1.sram_ub_l,
                     bus1.sram_lb_l, bus1.dtack_l, bus1.busy_h};

  always #5 clk = ~clk;

  // t counts edges from E0 (t=1 is the E0 edge); r is the first edge that samples AS_L=1.
  function automatic logic [9:0] model(int t, int r, int w, logic [1:0] blk, logic rw,
                                       logic uds, logic lds);
    logic [3:0] ce;
    ce = 4'b0001 << blk;
    ce = ~ce;
    if (t < r && t <= w + 1) return {ce, ~rw, rw, uds, lds, 2'b11};
    if (t < r) return {ce, ~rw, 1'b1, uds, lds, 2'b01};
    if (t == r) return RecoverV;
    return IdleV;
  endfunction

  function automatic logic excl_ok(logic [9:0] v);
    return ($countones(~v[9:6]) <= 1) && !(v[5] == 1'b0 && v[4] == 1'b0);
  endfunction

  task automatic check(string tag, logic [9:0] e0, logic [9:0] e1);
    logic [1:0] ex;
    tests++;
    assert (obs0 === e0) else begin
      fails++;
      $error("FAIL %s ws2 observed %b expected %b", tag, obs0, e0);
    end
    tests++;
    assert (obs1 === e1) else begin
      fails++;
      $error("FAIL %s ws0 observed %b expected %b", tag, obs1, e1);
    end
    ex = {excl_ok(obs0), excl_ok(obs1)};
    tests++;
    assert (ex === 2'b11) else begin
      fails++;
      $error("FAIL %s exclusivity observed %b expected 11", tag, ex);
    end
  endtask

  task automatic txn(string tag, logic [16:0] a, logic rw, logic uds, logic lds, int r,
                     int rst_at);
    logic [1:0] blk;
    blk = a[16:15];
    as_l = 1'b0;
    sel_h = 1'b1;
    addr = a;
    rw_h = rw;
    uds_l = uds;
    lds_l = lds;
    for (int t = 1; t <= r + 1; t++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s t=%0d", tag, t), model(t, r, W0, blk, rw, uds, lds),
            model(t, r, W1, blk, rw, uds, lds));
      if (t == rst_at) begin
        rst_n = 1'b0;
        #1;
        check({tag, " async_reset"}, IdleV, IdleV);
        as_l = 1'b1;
        sel_h = 1'b0;
        @(negedge clk);
        check({tag, " reset_held"}, IdleV, IdleV);
        rst_n = 1'b1;
        return;
      end
      // Scramble everything the responder must ignore once the cycle has started.
      addr = 17'($urandom);
      rw_h = 1'($urandom);
      uds_l = 1'($urandom);
      lds_l = 1'($urandom);
      sel_h = 1'($urandom);
      if (t + 1 >= r) as_l = 1'b1;
    end
    sel_h = 1'b0;
  endtask

  task automatic nostart(string tag, logic sel, logic uds, logic lds, int n);
    as_l = 1'b0;
    sel_h = sel;
    uds_l = uds;
    lds_l = lds;
    addr = 17'($urandom);
    rw_h = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s c=%0d", tag, i), IdleV, IdleV);
    end
    as_l = 1'b1;
    sel_h = 1'b0;
  endtask

  initial begin
    logic [1:0] s;
    repeat (2) @(negedge clk);
    check("reset", IdleV, IdleV);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", IdleV, IdleV);

    txn("read_blk1", 17'h08000, 1'b1, 1'b0, 1'b0, 6, 0);
    txn("write_lds_blk3", 17'h1FFFE, 1'b0, 1'b1, 1'b0, 6, 0);
    for (int b = 0; b < 4; b++) begin
      for (int rw = 0; rw < 2; rw++) begin
        txn($sformatf("sweep_b%0d_rw%0d", b, rw), {2'(b), 15'($urandom)}, 1'(rw), 1'b0,
            1'b0, 5, 0);
      end
    end
    txn("abort", 17'($urandom), 1'b1, 1'b0, 1'b0, 2, 0);
    txn("abort_write", 17'($urandom), 1'b0, 1'b0, 1'b1, 3, 0);
    txn("reset_in_ack", 17'h08000, 1'b1, 1'b0, 1'b0, 10, 5);
    txn("read_after_reset", 17'h08000, 1'b1, 1'b0, 1'b0, 6, 0);
    nostart("no_select", 1'b0, 1'b0, 1'b0, 4);
    nostart("no_strobes", 1'b1, 1'b1, 1'b1, 4);

    for (int i = 0; i < 30; i++) begin
      s = 2'(1 + $urandom_range(0, 2)) ^ 2'b11;
      txn($sformatf("rand%0d", i), 17'($urandom), 1'($urandom), s[1], s[0],
          2 + int'($urandom_range(0, 5)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
